// File: rtl/code_word_serializer.sv
// code_word_serializer
// Buffers one parallel code word behind a valid/ready handshake and shifts it
// out MSB-first, one bit per clock, with optional idle-0 gap cycles between
// frames. The idle level is 0 so a downstream detector only sees frame bits.
module code_word_serializer #(
    parameter int WIDTH      = 11,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             frame_start,
    output logic             frame_done,
    output logic [15:0]      words_sent
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    logic [1:0]       state;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;

    logic accept;
    logic last_bit;
    logic load;

    // Handshake and frame-boundary decode, all from registered state (plus abort/rst).
    assign word_ready = !hold_valid && !abort && !rst;
    assign accept     = word_valid && word_ready;
    assign last_bit   = (state == S_SHIFT) && (bit_cnt == '0);
    assign load       = hold_valid &&
                        ((state == S_IDLE) ||
                         (last_bit && (GAP_CYCLES == 0)) ||
                         ((state == S_GAP) && (gap_cnt == '0)));

    assign ser_active  = (state == S_SHIFT);
    assign ser_out     = ser_active && shreg[WIDTH-1];
    assign frame_start = ser_active && (bit_cnt == BIT_LAST);
    assign frame_done  = last_bit;

    // Hold buffer data: captured only on an accepted handshake.
    // NOTE: pure datapath storage qualified by hold_valid needs no reset; leaving it out keeps the reset net off the data flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= word_in;
        end
    end

    // Control FSM, shift register, counters and buffer-full flag.
    // NOTE: every register here uses <= so all updates see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_valid <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            words_sent <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            hold_valid <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // Loading is handled below; nothing else to do while idle.
                end
                S_SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        words_sent <= words_sent + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else if (!hold_valid) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A load overrides the per-state updates above; accept cannot
            // coincide because hold_valid is still set on the load edge.
            if (load) begin
                shreg      <= hold;
                bit_cnt    <= BIT_LAST;
                hold_valid <= 1'b0;
                state      <= S_SHIFT;
            end
        end
    end

endmodule
